// File: rtl/frame_fifo_read_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_fifo_read_if
// Brief    : App-side read port, FIFO status and frame request bundle for
//            frame_fifo_read.
// Revision : 1.0
// ============================================================================
interface frame_fifo_read_if #(
    parameter int ADDR_BITS = 21
);
    logic                 Sdr_init_done;
    logic                 App_wr_busy;
    logic                 O_rd_busy;
    logic                 App_rd_en;
    logic [ADDR_BITS-1:0] App_rd_addr;
    logic                 Sdr_rd_dval;
    logic                 read_req;
    logic                 read_req_ack;
    logic                 read_finish;
    logic [ADDR_BITS-1:0] read_addr_0;
    logic [ADDR_BITS-1:0] read_addr_1;
    logic [ADDR_BITS-1:0] read_addr_2;
    logic [ADDR_BITS-1:0] read_addr_3;
    logic [1:0]           read_addr_index;
    logic [ADDR_BITS-1:0] read_len;
    logic                 fifo_aclr;
    logic [9:0]           wrusedw;

    // master is the read engine, slave is the surrounding system
    modport master (
        input  Sdr_init_done, App_wr_busy, Sdr_rd_dval, read_req,
               read_addr_0, read_addr_1, read_addr_2, read_addr_3,
               read_addr_index, read_len, wrusedw,
        output O_rd_busy, App_rd_en, App_rd_addr, read_req_ack,
               read_finish, fifo_aclr
    );

    modport slave (
        output Sdr_init_done, App_wr_busy, Sdr_rd_dval, read_req,
               read_addr_0, read_addr_1, read_addr_2, read_addr_3,
               read_addr_index, read_len, wrusedw,
        input  O_rd_busy, App_rd_en, App_rd_addr, read_req_ack,
               read_finish, fifo_aclr
    );
endinterface
`default_nettype wire

// File: rtl/frame_fifo_read.sv
`default_nettype none
// ============================================================================
// Module   : frame_fifo_read
// Brief    : Frame read engine issuing word read bursts from SDRAM into the
//            display read FIFO. Optional macro FRAME_READ_DRAIN_EN delays
//            read_finish until every issued word has landed in the FIFO.
// Revision : 1.0
// ============================================================================
module frame_fifo_read #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 21,
    parameter int BURST_BITS    = 9,
    parameter int BURST_SIZE    = 128,
    parameter int FIFO_DEPTH    = 1024
) (
    input wire                 mem_clk,
    input wire                 rst,
    frame_fifo_read_if.master  bus
);

    localparam int c_sum_bits      = ADDR_BITS + 1;
    localparam int c_inflight_bits = 11;

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_ACK            = 3'd1,
        S_CHECK_FIFO     = 3'd2,
        S_READ_BURST     = 3'd3,
        S_READ_BURST_END = 3'd4,
        S_END            = 3'd5
`ifdef FRAME_READ_DRAIN_EN
        , S_DRAIN        = 3'd6
`endif
    } state_t;

    generate
        if (MEM_DATA_BITS < 1) begin : g_bad_mem_width
            $error("frame_fifo_read: MEM_DATA_BITS must be positive");
        end
    endgenerate

    state_t                     r_state;
    state_t                     w_next_state;

    logic                       r_req_d0;
    logic                       r_req_d1;
    logic                       r_req_d2;
    logic [ADDR_BITS-1:0]       r_len_d0;
    logic [ADDR_BITS-1:0]       r_len_d1;
    logic [1:0]                 r_index_d0;
    logic [1:0]                 r_index_d1;

    logic [ADDR_BITS-1:0]       r_len_latch;
    logic [ADDR_BITS-1:0]       r_read_cnt;
    logic [ADDR_BITS-1:0]       r_rd_addr;
    logic [BURST_BITS-1:0]      r_burst_len;
    logic [BURST_BITS-1:0]      r_burst_cnt;
    logic [c_inflight_bits-1:0] r_inflight;

    logic [c_sum_bits-1:0]      w_fill_sum;
    logic                       w_into_burst;
    logic [ADDR_BITS-1:0]       w_remaining;
    logic [BURST_BITS-1:0]      w_next_burst_len;
    logic [ADDR_BITS-1:0]       w_sel_addr;
    logic                       w_dval_take;

    logic                       w_rd_en;
    logic                       w_rd_busy;
    logic                       w_ack;
    logic                       w_aclr;
    logic                       w_finish;
    logic                       w_load_frame;
    logic                       w_load_burst;
    logic                       w_burst_done;

    // Worst-case fill assumes a whole burst lands on top of words still in flight
    assign w_fill_sum = c_sum_bits'(bus.wrusedw) + c_sum_bits'(r_inflight)
                      + c_sum_bits'(BURST_SIZE);
    assign w_into_burst = (w_fill_sum <= c_sum_bits'(FIFO_DEPTH)) && !bus.App_wr_busy;

    assign w_remaining      = r_len_latch - r_read_cnt;
    assign w_next_burst_len = (w_remaining > ADDR_BITS'(BURST_SIZE))
                            ? BURST_BITS'(BURST_SIZE)
                            : w_remaining[BURST_BITS-1:0];

    always_comb begin
        w_sel_addr = bus.read_addr_0;
        case (r_index_d1)
            2'd0:    w_sel_addr = bus.read_addr_0;
            2'd1:    w_sel_addr = bus.read_addr_1;
            2'd2:    w_sel_addr = bus.read_addr_2;
            default: w_sel_addr = bus.read_addr_3;
        endcase
    end

    assign w_dval_take = bus.Sdr_rd_dval && (r_inflight != '0);

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_rd_busy    = 1'b0;
        w_ack        = 1'b0;
        w_aclr       = 1'b0;
        w_finish     = 1'b0;
        w_load_frame = 1'b0;
        w_load_burst = 1'b0;
        w_burst_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_req_d2 && bus.Sdr_init_done) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                if (r_req_d2) begin
                    w_ack        = 1'b1;
                    w_aclr       = 1'b1;
                    w_load_frame = 1'b1;
                end else begin
                    w_next_state = S_CHECK_FIFO;
                end
            end
            S_CHECK_FIFO: begin
                if (r_req_d2) begin
                    w_next_state = S_ACK;
                end else if (w_into_burst) begin
                    w_rd_busy    = 1'b1;
                    w_load_burst = 1'b1;
                    w_next_state = S_READ_BURST;
                end
            end
            S_READ_BURST: begin
                w_rd_busy = 1'b1;
                if (r_burst_cnt < r_burst_len) begin
                    w_rd_en = 1'b1;
                end else begin
                    w_burst_done = 1'b1;
                    w_next_state = S_READ_BURST_END;
                end
            end
            S_READ_BURST_END: begin
                if (r_req_d2) begin
                    w_next_state = S_ACK;
                end else if (r_read_cnt < r_len_latch) begin
                    w_next_state = S_CHECK_FIFO;
                end else begin
`ifdef FRAME_READ_DRAIN_EN
                    w_next_state = S_DRAIN;
`else
                    w_next_state = S_END;
`endif
                end
            end
`ifdef FRAME_READ_DRAIN_EN
            S_DRAIN: begin
                if (r_inflight == '0) begin
                    w_next_state = S_END;
                end
            end
`endif
            S_END: begin
                w_finish     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_req_d0    <= 1'b0;
            r_req_d1    <= 1'b0;
            r_req_d2    <= 1'b0;
            r_len_d0    <= '0;
            r_len_d1    <= '0;
            r_index_d0  <= '0;
            r_index_d1  <= '0;
            r_len_latch <= '0;
            r_read_cnt  <= '0;
            r_rd_addr   <= '0;
            r_burst_len <= '0;
            r_burst_cnt <= '0;
            r_inflight  <= '0;
        end else begin
            r_req_d0   <= bus.read_req;
            r_req_d1   <= r_req_d0;
            r_req_d2   <= r_req_d1;
            r_len_d0   <= bus.read_len;
            r_len_d1   <= r_len_d0;
            r_index_d0 <= bus.read_addr_index;
            r_index_d1 <= r_index_d0;

            if (w_load_frame) begin
                r_len_latch <= r_len_d1;
                r_rd_addr   <= w_sel_addr;
                r_read_cnt  <= '0;
            end
            if (w_load_burst) begin
                r_burst_len <= w_next_burst_len;
                r_burst_cnt <= '0;
            end
            if (w_rd_en) begin
                r_rd_addr   <= r_rd_addr + 1'b1;
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            if (w_burst_done) begin
                r_read_cnt <= r_read_cnt + ADDR_BITS'(r_burst_len);
            end

            // A restart flushes the FIFO, so words still in flight no longer count
            if (w_load_frame) begin
                r_inflight <= '0;
            end else if (w_rd_en && !w_dval_take) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_rd_en && w_dval_take) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end
    end

    assign bus.App_rd_en    = w_rd_en;
    assign bus.App_rd_addr  = r_rd_addr;
    assign bus.O_rd_busy    = w_rd_busy;
    assign bus.read_req_ack = w_ack;
    assign bus.fifo_aclr    = w_aclr;
    assign bus.read_finish  = w_finish;

endmodule
`default_nettype wire
